// File: rtl/tlu_coinc_trig.sv
// Coincidence trigger stage for the TLU receivers.
// Combines per-channel VALID / leading-edge info into a registered trigger pulse,
// a wrapping trigger number and a trigger data word on a valid/ready interface,
// followed by a programmable hold-off.
module tlu_coinc_trig #(
  parameter int unsigned N_CH = 6
) (
  input  logic                CLK40,
  input  logic                RST,
  input  logic [N_CH-1:0]     CH_VALID,
  input  logic [8*N_CH-1:0]   CH_LE_REL,
  input  logic [8*N_CH-1:0]   CH_TOT,
  input  logic [N_CH-1:0]     EN_MASK,
  input  logic [N_CH-1:0]     VETO_MASK,
  input  logic [7:0]          MAX_SPREAD,
  input  logic [7:0]          HOLDOFF,
  input  logic [31:0]         TIME_STAMP,
  output logic                TRIG,
  output logic                BUSY,
  output logic [15:0]         TRIG_CNT,
  output logic [15:0]         SKIP_CNT,
  output logic                DATA_VALID,
  input  logic                DATA_READY,
  output logic [55+N_CH:0]    DATA
);

  localparam int unsigned DataW = 56 + N_CH;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             trig_q, trig_d;
  logic [15:0]      trig_cnt_q, trig_cnt_d;
  logic [15:0]      skip_cnt_q, skip_cnt_d;
  logic             data_valid_q, data_valid_d;
  logic [DataW-1:0] data_q, data_d;

  logic [7:0]       le_max, le_min, spread;
  logic             coinc;
  logic             fire;
  logic             xfer;
  logic [15:0]      trig_cnt_inc;

  // TOT thresholding lives in the receivers; the bus is accepted but not used here.
  logic unused_tot;
  assign unused_tot = ^CH_TOT;

  // Leading-edge extremes over enabled channels and the resulting coincidence term.
  always_comb begin
    le_max = 8'h00;
    le_min = 8'hff;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (EN_MASK[i]) begin
        if (CH_LE_REL[8*i +: 8] > le_max) le_max = CH_LE_REL[8*i +: 8];
        if (CH_LE_REL[8*i +: 8] < le_min) le_min = CH_LE_REL[8*i +: 8];
      end
    end
    // Only meaningful when EN_MASK != 0, in which case le_max >= le_min.
    spread = le_max - le_min;
    coinc  = (EN_MASK != '0) &&
             ((CH_VALID & EN_MASK) == EN_MASK) &&
             ((CH_VALID & VETO_MASK) == '0) &&
             (spread <= MAX_SPREAD);
  end

  // Trigger / hold-off state machine: next state and hold-off counter.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    fire       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (coinc) begin
          fire       = 1'b1;
          hold_cnt_d = HOLDOFF;
          if (HOLDOFF != 8'd0) state_d = StHold;
        end
      end
      StHold: begin
        // Counter value 1 marks the last BUSY cycle.
        if (hold_cnt_q <= 8'd1) state_d = StIdle;
        hold_cnt_d = (hold_cnt_q != 8'd0) ? hold_cnt_q - 8'd1 : 8'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign xfer         = data_valid_q & DATA_READY;
  assign trig_cnt_inc = trig_cnt_q + 16'd1;

  // Trigger outputs, counters and the data word handshake.
  always_comb begin
    trig_d       = fire;
    trig_cnt_d   = trig_cnt_q;
    skip_cnt_d   = skip_cnt_q;
    data_valid_d = data_valid_q;
    data_d       = data_q;
    if (fire) begin
      trig_cnt_d = trig_cnt_inc;
      if (!data_valid_q || xfer) begin
        data_d       = {trig_cnt_inc, TIME_STAMP, le_max, CH_VALID};
        data_valid_d = 1'b1;
      end else if (skip_cnt_q != 16'hffff) begin
        // Old word is kept; the gap in trigger numbers is visible downstream.
        skip_cnt_d = skip_cnt_q + 16'd1;
      end
    end else if (xfer) begin
      data_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      state_q      <= StIdle;
      hold_cnt_q   <= 8'd0;
      trig_q       <= 1'b0;
      trig_cnt_q   <= 16'd0;
      skip_cnt_q   <= 16'd0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      trig_q       <= trig_d;
      trig_cnt_q   <= trig_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
    end
  end

  assign TRIG       = trig_q;
  assign BUSY       = (state_q == StHold);
  assign TRIG_CNT   = trig_cnt_q;
  assign SKIP_CNT   = skip_cnt_q;
  assign DATA_VALID = data_valid_q;
  assign DATA       = data_q;

endmodule

// File: tb/tb_tlu_coinc_trig.sv
// Directed self-checking bench for tlu_coinc_trig (N_CH = 6).
module tb_tlu_coinc_trig;

  localparam int unsigned N_CH = 6;

  logic              CLK40;
  logic              RST;
  logic [N_CH-1:0]   CH_VALID;
  logic [8*N_CH-1:0] CH_LE_REL;
  logic [8*N_CH-1:0] CH_TOT;
  logic [N_CH-1:0]   EN_MASK;
  logic [N_CH-1:0]   VETO_MASK;
  logic [7:0]        MAX_SPREAD;
  logic [7:0]        HOLDOFF;
  logic [31:0]       TIME_STAMP;
  logic              TRIG;
  logic              BUSY;
  logic [15:0]       TRIG_CNT;
  logic [15:0]       SKIP_CNT;
  logic              DATA_VALID;
  logic              DATA_READY;
  logic [55+N_CH:0]  DATA;

  int total = 0;
  int bad   = 0;

  tlu_coinc_trig #(.N_CH(N_CH)) dut (
    .CLK40      (CLK40),
    .RST        (RST),
    .CH_VALID   (CH_VALID),
    .CH_LE_REL  (CH_LE_REL),
    .CH_TOT     (CH_TOT),
    .EN_MASK    (EN_MASK),
    .VETO_MASK  (VETO_MASK),
    .MAX_SPREAD (MAX_SPREAD),
    .HOLDOFF    (HOLDOFF),
    .TIME_STAMP (TIME_STAMP),
    .TRIG       (TRIG),
    .BUSY       (BUSY),
    .TRIG_CNT   (TRIG_CNT),
    .SKIP_CNT   (SKIP_CNT),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .DATA       (DATA)
  );

  initial begin
    CLK40 = 1'b0;
    forever #12 CLK40 = ~CLK40;
  end

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    CH_VALID   = '0;
    CH_LE_REL  = '0;
    CH_TOT     = '1;
    EN_MASK    = '0;
    VETO_MASK  = '0;
    MAX_SPREAD = 8'd16;
    HOLDOFF    = 8'd0;
    TIME_STAMP = 32'd0;
    DATA_READY = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL rst_trig got=%0h exp=0", TRIG); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", BUSY); end
    total++; if (TRIG_CNT !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", TRIG_CNT); end
    total++; if (SKIP_CNT !== 16'd0) begin bad++; $display("FAIL rst_skip got=%0h exp=0", SKIP_CNT); end
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL rst_dv got=%0h exp=0", DATA_VALID); end
    total++; if (DATA !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", DATA); end
  endtask

  // Basic trigger with hold-off of 4 cycles.
  task automatic test_basic_holdoff();
    logic [61:0] exp_data;
    do_reset();
    EN_MASK = 6'b000011; CH_VALID = 6'b000011;
    CH_LE_REL[7:0] = 8'd60; CH_LE_REL[15:8] = 8'd50;
    MAX_SPREAD = 8'd16; HOLDOFF = 8'd4; TIME_STAMP = 32'h100;
    step();
    TIME_STAMP = 32'h101;
    exp_data = {16'd1, 32'h100, 8'd60, 6'b000011};
    total++; if (TRIG !== 1'b1) begin bad++; $display("FAIL basic_trig got=%0h exp=1", TRIG); end
    total++; if (TRIG_CNT !== 16'd1) begin bad++; $display("FAIL basic_cnt got=%0h exp=1", TRIG_CNT); end
    total++; if (DATA_VALID !== 1'b1) begin bad++; $display("FAIL basic_dv got=%0h exp=1", DATA_VALID); end
    total++; if (DATA !== exp_data) begin bad++; $display("FAIL basic_data got=%0h exp=%0h", DATA, exp_data); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy1 got=%0h exp=1", BUSY); end
    for (int i = 2; i <= 4; i++) begin
      if (i == 3) HOLDOFF = 8'd1;  // must not disturb the running hold-off
      step();
      total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy%0d got=%0h exp=1", i, BUSY); end
      total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL basic_notrig%0d got=%0h exp=0", i, TRIG); end
    end
    step();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0h exp=0", BUSY); end
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL basic_notrig5 got=%0h exp=0", TRIG); end
    total++; if (TRIG_CNT !== 16'd1) begin bad++; $display("FAIL basic_cnt_end got=%0h exp=1", TRIG_CNT); end
    CH_VALID = '0; DATA_READY = 1'b1;
    step();
    DATA_READY = 1'b0;
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0h exp=0", DATA_VALID); end
  endtask

  // Spread check: 30 rejected, exactly MAX_SPREAD accepted.
  task automatic test_spread();
    logic [61:0] exp_data;
    do_reset();
    EN_MASK = 6'b000011; CH_VALID = 6'b000011;
    CH_LE_REL[7:0] = 8'd80; CH_LE_REL[15:8] = 8'd50;
    MAX_SPREAD = 8'd16; HOLDOFF = 8'd4; TIME_STAMP = 32'h100;
    step(); step();
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL spread_wide_trig got=%0h exp=0", TRIG); end
    total++; if (TRIG_CNT !== 16'd0) begin bad++; $display("FAIL spread_wide_cnt got=%0h exp=0", TRIG_CNT); end
    CH_LE_REL[7:0] = 8'd66; TIME_STAMP = 32'h155;
    step();
    exp_data = {16'd1, 32'h155, 8'd66, 6'b000011};
    total++; if (TRIG !== 1'b1) begin bad++; $display("FAIL spread_edge_trig got=%0h exp=1", TRIG); end
    total++; if (DATA !== exp_data) begin bad++; $display("FAIL spread_edge_data got=%0h exp=%0h", DATA, exp_data); end
  endtask

  // Veto blocks; releasing the veto channel triggers next cycle; overlap veto wins.
  task automatic test_veto();
    logic [61:0] exp_data;
    do_reset();
    EN_MASK = 6'b000011; VETO_MASK = 6'b000100; CH_VALID = 6'b000111;
    CH_LE_REL[7:0] = 8'd60; CH_LE_REL[15:8] = 8'd50; TIME_STAMP = 32'h42;
    step();
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL veto_block got=%0h exp=0", TRIG); end
    CH_VALID = 6'b000011;
    step();
    exp_data = {16'd1, 32'h42, 8'd60, 6'b000011};
    total++; if (TRIG !== 1'b1) begin bad++; $display("FAIL veto_release got=%0h exp=1", TRIG); end
    total++; if (DATA !== exp_data) begin bad++; $display("FAIL veto_data got=%0h exp=%0h", DATA, exp_data); end
    VETO_MASK = 6'b000001;
    step();
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL veto_overlap got=%0h exp=0", TRIG); end
    total++; if (TRIG_CNT !== 16'd1) begin bad++; $display("FAIL veto_cnt got=%0h exp=1", TRIG_CNT); end
  endtask

  // Back-pressure skips, drain, then trigger coincident with a transfer.
  task automatic test_back_to_back();
    logic [61:0] exp_data;
    do_reset();
    EN_MASK = 6'b000011; CH_VALID = 6'b000011;
    CH_LE_REL[7:0] = 8'd60; CH_LE_REL[15:8] = 8'd50;
    HOLDOFF = 8'd0; DATA_READY = 1'b0; TIME_STAMP = 32'h200;
    step(); TIME_STAMP = 32'h201;
    step(); TIME_STAMP = 32'h202;
    step();
    exp_data = {16'd1, 32'h200, 8'd60, 6'b000011};
    total++; if (TRIG_CNT !== 16'd3) begin bad++; $display("FAIL bp_cnt got=%0h exp=3", TRIG_CNT); end
    total++; if (SKIP_CNT !== 16'd2) begin bad++; $display("FAIL bp_skip got=%0h exp=2", SKIP_CNT); end
    total++; if (DATA !== exp_data) begin bad++; $display("FAIL bp_data got=%0h exp=%0h", DATA, exp_data); end
    total++; if (TRIG !== 1'b1) begin bad++; $display("FAIL bp_trig got=%0h exp=1", TRIG); end
    CH_VALID = '0; DATA_READY = 1'b1;
    step();
    DATA_READY = 1'b0;
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0h exp=0", DATA_VALID); end
    CH_VALID = 6'b000011; TIME_STAMP = 32'h300;
    step();
    total++; if (DATA_VALID !== 1'b1) begin bad++; $display("FAIL x_dv1 got=%0h exp=1", DATA_VALID); end
    DATA_READY = 1'b1; TIME_STAMP = 32'h301;
    step();
    exp_data = {16'd5, 32'h301, 8'd60, 6'b000011};
    total++; if (DATA_VALID !== 1'b1) begin bad++; $display("FAIL x_dv2 got=%0h exp=1", DATA_VALID); end
    total++; if (DATA !== exp_data) begin bad++; $display("FAIL x_data got=%0h exp=%0h", DATA, exp_data); end
    total++; if (SKIP_CNT !== 16'd2) begin bad++; $display("FAIL x_skip got=%0h exp=2", SKIP_CNT); end
    DATA_READY = 1'b0; CH_VALID = '0;
    step();
  endtask

  // Counter wrap, skip saturation, reset during hold, empty enable mask.
  task automatic test_wrap_reset();
    logic [61:0] exp_data;
    do_reset();
    EN_MASK = 6'b000011; CH_VALID = 6'b000011;
    CH_LE_REL[7:0] = 8'd60; CH_LE_REL[15:8] = 8'd50;
    HOLDOFF = 8'd0; DATA_READY = 1'b0; TIME_STAMP = 32'h7;
    for (int i = 0; i < 65535; i++) step();
    total++; if (TRIG_CNT !== 16'hffff) begin bad++; $display("FAIL wrap_pre got=%0h exp=ffff", TRIG_CNT); end
    total++; if (SKIP_CNT !== 16'hfffe) begin bad++; $display("FAIL skip_pre got=%0h exp=fffe", SKIP_CNT); end
    step();
    total++; if (TRIG_CNT !== 16'h0000) begin bad++; $display("FAIL wrap got=%0h exp=0", TRIG_CNT); end
    total++; if (SKIP_CNT !== 16'hffff) begin bad++; $display("FAIL skip_max got=%0h exp=ffff", SKIP_CNT); end
    step();
    total++; if (SKIP_CNT !== 16'hffff) begin bad++; $display("FAIL skip_sat got=%0h exp=ffff", SKIP_CNT); end
    HOLDOFF = 8'd5;
    step();
    exp_data = {16'd1, 32'h7, 8'd60, 6'b000011};
    total++; if (TRIG_CNT !== 16'd2) begin bad++; $display("FAIL hold_cnt got=%0h exp=2", TRIG_CNT); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL hold_busy got=%0h exp=1", BUSY); end
    total++; if (DATA !== exp_data) begin bad++; $display("FAIL hold_data got=%0h exp=%0h", DATA, exp_data); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst2_busy got=%0h exp=0", BUSY); end
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL rst2_trig got=%0h exp=0", TRIG); end
    total++; if (TRIG_CNT !== 16'd0) begin bad++; $display("FAIL rst2_cnt got=%0h exp=0", TRIG_CNT); end
    total++; if (SKIP_CNT !== 16'd0) begin bad++; $display("FAIL rst2_skip got=%0h exp=0", SKIP_CNT); end
    total++; if (DATA_VALID !== 1'b0) begin bad++; $display("FAIL rst2_dv got=%0h exp=0", DATA_VALID); end
    total++; if (DATA !== '0) begin bad++; $display("FAIL rst2_data got=%0h exp=0", DATA); end
    EN_MASK = '0; CH_VALID = 6'b111111; HOLDOFF = 8'd0;
    step(); step();
    total++; if (TRIG !== 1'b0) begin bad++; $display("FAIL noen_trig got=%0h exp=0", TRIG); end
    total++; if (TRIG_CNT !== 16'd0) begin bad++; $display("FAIL noen_cnt got=%0h exp=0", TRIG_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic_holdoff();
    test_spread();
    test_veto();
    test_back_to_back();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlu_coinc_trig.md
Name: tlu_coinc_trig

Overview:
- Downstream stage of the per-channel TLU receivers, running in the CLK40 domain.
- Combines the per-channel VALID, LAST_RISING_REL and LAST_TOT outputs of N_CH receivers into a trigger decision:
  - enabled-channel coincidence;
  - veto channels;
  - leading-edge time-spread check.
- On a trigger it emits a one-cycle trigger pulse, increments a trigger number and offers a trigger data word on a valid/ready interface to the trigger FIFO.
- After each trigger, a programmable hold-off suppresses retriggering while channel VALID windows are still open.

Parameters:
- N_CH, 6, number of receiver channels (1..8).

Ports:
- CLK40  input  1  system clock, 40 MHz.
- RST  input  1  reset, synchronous, active-high.
- CH_VALID  input  N_CH  per-channel VALID from the receivers.
- CH_LE_REL  input  8*N_CH  per-channel LAST_RISING_REL, in 1/16-cycle units; channel k occupies [8k+7:8k].
- CH_TOT  input  8*N_CH  per-channel LAST_TOT, in 1/16-cycle units; 8'hff means the trailing edge is still pending.
- EN_MASK  input  N_CH  channels that must all be valid for a coincidence.
- VETO_MASK  input  N_CH  channels whose VALID blocks a trigger.
- MAX_SPREAD  input  8  maximum allowed leading-edge spread, in 1/16-cycle units.
- HOLDOFF  input  8  dead time after a trigger, in CLK40 cycles.
- TIME_STAMP  input  32  free-running CLK40 timestamp.
- TRIG  output  1  one-cycle trigger pulse.
- BUSY  output  1  high while in hold-off.
- TRIG_CNT  output  16  number of triggers issued; wraps.
- SKIP_CNT  output  16  trigger data words dropped due to back-pressure; saturates.
- DATA_VALID  output  1  trigger data word available.
- DATA_READY  input  1  consumer accepts the data word.
- DATA  output  56+N_CH  {TRIG_CNT_new[15:0], TS[31:0], LE_MAX[7:0], CH_VALID snapshot[N_CH-1:0]}.

Behaviour:
- Reset: TRIG=0, BUSY=0, TRIG_CNT=0, SKIP_CNT=0, DATA_VALID=0, DATA=0, state=IDLE, hold-off counter=0. RST overrides everything, including a pending transfer, and discards any held data word.
- Combinational coincidence term COINC:
  - EN_MASK != 0;
  - (CH_VALID & EN_MASK) == EN_MASK;
  - (CH_VALID & VETO_MASK) == 0;
  - SPREAD <= MAX_SPREAD.
- A channel set in both EN_MASK and VETO_MASK can never trigger; veto wins.
- SPREAD = LE_MAX - LE_MIN, where LE_MAX and LE_MIN are the max and min of CH_LE_REL over enabled channels. The result is 8-bit unsigned with no wrap, since max >= min. A larger LE_REL means an earlier edge, so LE_MAX is the earliest leading edge.
- CH_TOT is not gated here; thresholding is done in the receivers.
- State machine:
  - IDLE: if COINC in cycle N, then in cycle N+1:
    - TRIG=1;
    - TRIG_CNT += 1, wrapping 0xFFFF->0;
    - TS = TIME_STAMP sampled in cycle N;
    - DATA offered per the handshake rules below;
    - hold-off counter loaded with HOLDOFF;
    - state -> HOLD if HOLDOFF != 0, otherwise stays IDLE.
  - HOLD: BUSY=1, COINC ignored, counter decrements each cycle. When the counter reaches 1 (i.e. HOLDOFF cycles of BUSY have elapsed) -> IDLE. IDLE may trigger in the first cycle after BUSY drops.
  - HOLDOFF=0: a coincidence held for several cycles triggers every cycle.
  - HOLDOFF is sampled only at trigger; changes during HOLD do not affect the running count.
- Latency: COINC to TRIG/DATA_VALID is exactly 1 cycle. TRIG is registered.
- Handshake:
  - A transfer occurs on a posedge with DATA_VALID & DATA_READY.
  - DATA and DATA_VALID are held stable until the transfer.
  - After a transfer with no new trigger, DATA_VALID=0 on the next cycle.
- New trigger when DATA_VALID=0, or when a transfer happens in that same cycle: new word loaded, DATA_VALID=1, no skip.
- New trigger when DATA_VALID=1 & DATA_READY=0:
  - old word kept;
  - SKIP_CNT += 1, saturating at 0xFFFF;
  - TRIG still pulses and TRIG_CNT still increments, so the numbering gap is visible downstream.
- EN_MASK, VETO_MASK and MAX_SPREAD are quasi-static but may be changed at any time; they take effect on the next COINC evaluation.

Test Plan:
1. EN_MASK=6'b000011, ch0/ch1 VALID with LE_REL 60/50, MAX_SPREAD=16, HOLDOFF=4, TIME_STAMP=0x100 -> TRIG one cycle later; TRIG_CNT=1; DATA={16'd1, 32'h100, 8'd60, 6'b000011}; BUSY high for 4 cycles; no second trigger while VALIDs stay high during hold-off.
2. Same as scenario 1 but LE_REL 80/50 (spread 30 > 16) -> no TRIG; TRIG_CNT stays 0.
3. Coincidence present plus VETO_MASK=6'b000100 with ch2 VALID -> no trigger. Clearing ch2 VALID -> trigger on the following cycle.
4. DATA_READY=0, HOLDOFF=0, coincidence held 3 cycles -> TRIG_CNT=3, SKIP_CNT=2, DATA still holds the word with TRIG_CNT=1. Then DATA_READY=1 for 1 cycle with the coincidence removed -> DATA_VALID falls the next cycle.
5. Trigger coincident with a transfer (DATA_VALID=1, DATA_READY=1, COINC) -> new word loaded, DATA_VALID stays 1, SKIP_CNT unchanged.
6. Preload TRIG_CNT to 0xFFFF via repeated triggers, then trigger once more -> TRIG_CNT=0. Assert RST during HOLD with DATA_VALID=1 -> all outputs at reset values the next cycle; EN_MASK=0 with all channels VALID -> no trigger.
